// File: rtl/synth_pkg.sv
// Shared definitions for the envelope generator: phase encoding, default width
// and full-scale level.
package synth_pkg;

  localparam int unsigned WIDTH_DEF = 12;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned LEVEL_MAX = (1 << WIDTH_DEF) - 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Phases in which a note-off moves the envelope into release.
  function automatic logic note_held(input logic [STATE_W-1:0] st);
    return (st == ST_ATTACK) || (st == ST_DECAY) || (st == ST_SUSTAIN);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Registers a level input and flags its rising and falling edges against the
// registered copy.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/envelope_generator.sv
// ADSR envelope generator: tick-stepped level with a saturating attack adder and
// decay/release driven through an external subtract stage.
module envelope_generator
  import synth_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] release_step,
  input  logic [WIDTH-1:0] sustain_level,
  output logic [WIDTH-1:0] sub_lhs,
  output logic [WIDTH-1:0] sub_rhs,
  input  logic [WIDTH-1:0] sub_result,
  input  logic             sub_overflow,
  output logic [WIDTH-1:0] level,
  output logic [2:0]       state,
  output logic             active
);

  localparam logic [WIDTH-1:0] LEVEL_TOP  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   FULL_SCALE = {1'b0, LEVEL_TOP};

  logic             rise;
  logic             fall;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH:0]   attack_sum;
  logic             attack_full;
  logic             decay_done;
  logic             release_done;

  edge_detector u_gate_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gate),
    .rise (rise),
    .fall (fall)
  );

  // One extra bit keeps the carry so the clamp sees true overshoot.
  assign attack_sum   = {1'b0, level} + {1'b0, attack_step};
  assign attack_full  = attack_sum >= FULL_SCALE;
  assign decay_done   = sub_overflow || (sub_result <= sustain_level);
  assign release_done = sub_overflow || (sub_result == '0);

  assign sub_lhs = level;

  always_comb begin
    sub_rhs = '0;
    case (state)
      ST_DECAY:   sub_rhs = decay_step;
      ST_RELEASE: sub_rhs = release_step;
      default:    sub_rhs = '0;
    endcase
  end

  // Gate edges take priority and suppress any level step in the same cycle.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (rise) begin
      state_nxt = ST_ATTACK;
    end else if (fall) begin
      if (note_held(state)) begin
        state_nxt = ST_RELEASE;
      end
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          level_nxt = level;
        end
        ST_ATTACK: begin
          if (attack_full) begin
            level_nxt = LEVEL_TOP;
            state_nxt = ST_DECAY;
          end else begin
            level_nxt = attack_sum[WIDTH-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_done) begin
            level_nxt = sustain_level;
            state_nxt = ST_SUSTAIN;
          end else begin
            level_nxt = sub_result;
          end
        end
        ST_SUSTAIN: begin
          level_nxt = sustain_level;
        end
        ST_RELEASE: begin
          if (release_done) begin
            level_nxt = '0;
            state_nxt = ST_IDLE;
          end else begin
            level_nxt = sub_result;
          end
        end
        default: begin
          level_nxt = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      level  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      active <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_envelope_generator.sv
// Bench for envelope_generator: directed ADSR scenarios plus randomized
// gate/tick/step traffic against an arithmetic envelope model.
module tb_envelope_generator;
  import synth_pkg::*;

  localparam int W = 12;
  localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;

  logic         clk = 1'b0;
  logic         rst, tick, gate;
  logic [W-1:0] attack_step, decay_step, release_step, sustain_level;
  logic [W-1:0] sub_lhs, sub_rhs, sub_result, level;
  logic         sub_overflow, active;
  logic [2:0]   state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int   m_level = 0;
  int   m_phase = M_IDLE;
  logic m_gate  = 1'b0;

  envelope_generator #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .sustain_level (sustain_level),
    .sub_lhs       (sub_lhs),
    .sub_rhs       (sub_rhs),
    .sub_result    (sub_result),
    .sub_overflow  (sub_overflow),
    .level         (level),
    .state         (state),
    .active        (active)
  );

  // External subtract stage
  assign sub_result   = sub_lhs - sub_rhs;
  assign sub_overflow = sub_rhs > sub_lhs;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_env(input string name, input int lvl, input logic [2:0] st);
    check({name, "_level"}, int'(level), lvl);
    check({name, "_state"}, int'(state), int'(st));
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc(input int p);
    case (p)
      M_ATTACK:  return ST_ATTACK;
      M_DECAY:   return ST_DECAY;
      M_SUSTAIN: return ST_SUSTAIN;
      M_RELEASE: return ST_RELEASE;
      default:   return ST_IDLE;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_step();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(1, 31));
      2:       return W'($urandom_range(32, 511));
      default: return W'($urandom_range(0, LEVEL_MAX));
    endcase
  endfunction

  // Reference envelope: signed integer arithmetic, no borrow logic.
  initial forever begin
    int nxt;
    logic rise_e, fall_e;
    @(posedge clk);
    if (rst) begin
      m_level = 0;
      m_phase = M_IDLE;
      m_gate  = 1'b0;
    end else begin
      rise_e = gate && !m_gate;
      fall_e = !gate && m_gate;
      m_gate = gate;
      if (rise_e) begin
        m_phase = M_ATTACK;
      end else if (fall_e) begin
        if (m_phase == M_ATTACK || m_phase == M_DECAY || m_phase == M_SUSTAIN)
          m_phase = M_RELEASE;
      end else if (tick) begin
        if (m_phase == M_ATTACK) begin
          nxt = m_level + int'(attack_step);
          if (nxt >= int'(LEVEL_MAX)) begin
            m_level = int'(LEVEL_MAX);
            m_phase = M_DECAY;
          end else m_level = nxt;
        end else if (m_phase == M_DECAY) begin
          nxt = m_level - int'(decay_step);
          if (nxt <= int'(sustain_level)) begin
            m_level = int'(sustain_level);
            m_phase = M_SUSTAIN;
          end else m_level = nxt;
        end else if (m_phase == M_SUSTAIN) begin
          m_level = int'(sustain_level);
        end else if (m_phase == M_RELEASE) begin
          nxt = m_level - int'(release_step);
          if (nxt <= 0) begin
            m_level = 0;
            m_phase = M_IDLE;
          end else m_level = nxt;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    int exp_rhs;
    @(negedge clk);
    if (chk_en) begin
      exp_rhs = (m_phase == M_DECAY)   ? int'(decay_step) :
                (m_phase == M_RELEASE) ? int'(release_step) : 0;
      check("m_level",   int'(level),   m_level);
      check("m_state",   int'(state),   int'(enc(m_phase)));
      check("m_active",  int'(active),  (m_phase != M_IDLE) ? 1 : 0);
      check("m_sub_lhs", int'(sub_lhs), m_level);
      check("m_sub_rhs", int'(sub_rhs), exp_rhs);
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active !== 1'b0 && n < budget) begin
      clk1();
      n++;
    end
    check("drain_timeout_active", int'(active), 0);
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0; tick = 1'b0;
    attack_step = 12'd1024; decay_step = 12'd1000;
    release_step = 12'd900; sustain_level = 12'd2000;
    clk1();
    chk_en = 1'b1;
    clk1();
    expect_env("reset", 0, ST_IDLE);
    check("reset_active", int'(active), 0);

    // Attack to full scale
    rst = 1'b0; gate = 1'b1; tick = 1'b1;
    clk1(); expect_env("rise_no_step", 0, ST_ATTACK);
    clk1(); expect_env("att1", 1024, ST_ATTACK);
    clk1(); expect_env("att2", 2048, ST_ATTACK);
    clk1(); expect_env("att3", 3072, ST_ATTACK);
    clk1(); expect_env("att_clamp", 4095, ST_DECAY);

    // Decay to sustain
    clk1(); expect_env("dec1", 3095, ST_DECAY);
    clk1(); expect_env("dec2", 2095, ST_DECAY);
    clk1(); expect_env("dec_clamp", 2000, ST_SUSTAIN);

    // Release to idle via borrow
    gate = 1'b0;
    clk1(); expect_env("fall_rel", 2000, ST_RELEASE);
    clk1(); expect_env("rel1", 1100, ST_RELEASE);
    clk1(); expect_env("rel2", 200, ST_RELEASE);
    clk1(); expect_env("rel_ovf", 0, ST_IDLE);
    check("rel_active", int'(active), 0);

    // Note-off mid-attack, retrigger mid-release
    gate = 1'b1;
    clk1(); expect_env("re_rise", 0, ST_ATTACK);
    clk1(); expect_env("re_att1", 1024, ST_ATTACK);
    clk1(); expect_env("re_att2", 2048, ST_ATTACK);
    gate = 1'b0;
    clk1(); expect_env("att_fall", 2048, ST_RELEASE);
    release_step = 12'd948;
    clk1(); expect_env("rel_1100", 1100, ST_RELEASE);
    gate = 1'b1;
    clk1(); expect_env("retrigger", 1100, ST_ATTACK);
    clk1(); expect_env("retrig_att", 2124, ST_ATTACK);

    tick = 1'b0;
    repeat (10) begin
      clk1(); expect_env("no_tick", 2124, ST_ATTACK);
    end
    tick = 1'b1;
    clk1(); expect_env("att_resume", 3148, ST_ATTACK);
    clk1(); expect_env("att_clamp2", 4095, ST_DECAY);
    clk1(); expect_env("dec_3095", 3095, ST_DECAY);

    // Reset mid-decay with gate held high
    rst = 1'b1;
    clk1(); expect_env("rst_abort", 0, ST_IDLE);
    check("rst_active", int'(active), 0);
    rst = 1'b0;
    clk1(); expect_env("rst_rise", 0, ST_ATTACK);
    check("rst_rise_active", int'(active), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 599) == 0);
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 15) == 0) attack_step   = rnd_step();
      if ($urandom_range(0, 15) == 0) decay_step    = rnd_step();
      if ($urandom_range(0, 15) == 0) release_step  = rnd_step();
      if ($urandom_range(0, 31) == 0) sustain_level = W'($urandom_range(0, LEVEL_MAX));
      clk1();
    end

    // Drain back to idle
    rst = 1'b0; gate = 1'b0; tick = 1'b1; release_step = 12'd512;
    wait_idle(64);
    expect_env("drain", 0, ST_IDLE);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample/level width matching the subtract stage.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle sample-rate strobe; level steps only on tick.
REQ-005 SHALL have port gate  input  1  note on (1) / note off (0).
REQ-006 SHALL have ports attack_step, decay_step, release_step  input  WIDTH  per-tick level increments.
REQ-007 SHALL have port sustain_level  input  WIDTH  decay target / held level.
REQ-008 SHALL have ports sub_lhs, sub_rhs  output  WIDTH  operands driven to the external subtract stage.
REQ-009 SHALL have ports sub_result  input  WIDTH and sub_overflow  input  1  from the subtract stage; overflow means rhs > lhs (borrow).
REQ-010 SHALL have port level  output  WIDTH  registered envelope value.
REQ-011 SHALL have port state  output  3  current phase encoding.
REQ-012 SHALL have port active  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-014 SHALL register gate internally and detect rising and falling edges against the registered copy.
REQ-015 Gate rising edge in any state SHALL enter ATTACK next cycle, keeping current level (retrigger, no reset to 0).
REQ-016 Gate falling edge in ATTACK, DECAY or SUSTAIN SHALL enter RELEASE next cycle; in IDLE/RELEASE it SHALL be ignored.
REQ-017 On a cycle with a gate edge, the edge transition SHALL win and level SHALL NOT step, even if tick is high.
REQ-018 ATTACK on tick: level <= level + attack_step computed at WIDTH+1 bits; sum >= 2^WIDTH-1 SHALL clamp level to 2^WIDTH-1 and enter DECAY.
REQ-019 DECAY on tick: if sub_overflow or sub_result <= sustain_level, level <= sustain_level and enter SUSTAIN; else level <= sub_result.
REQ-020 SUSTAIN on tick: level <= sustain_level (tracks live changes); state held until gate falls.
REQ-021 RELEASE on tick: if sub_overflow or sub_result == 0, level <= 0 and enter IDLE; else level <= sub_result.
REQ-022 IDLE SHALL hold level; level is 0 on any normal entry to IDLE.
REQ-023 sub_lhs SHALL equal level combinationally; sub_rhs SHALL be decay_step in DECAY, release_step in RELEASE, 0 otherwise.
REQ-024 Step value 0 SHALL hold level and state indefinitely (no forced transition).
REQ-025 Without tick, level and state SHALL change only through gate edges.
REQ-026 Latency: level update visible one clk after the tick cycle; state change one clk after edge/tick cycle.

Reset
REQ-027 rst SHALL set state IDLE, level 0, active 0, registered gate 0; rst overrides gate and tick in the same cycle.
REQ-028 rst mid-envelope SHALL abort immediately to IDLE/0; gate held high through reset release SHALL register as a rising edge one cycle after rst deasserts.

Structure
REQ-029 State encoding, WIDTH default and LEVEL_MAX (2^WIDTH-1) SHALL live in shared package synth_pkg.
REQ-030 Gate edge detection SHALL be a sub-module edge_detector (outputs rise, fall); the FSM and saturating adder stay in envelope_generator.
REQ-031 The subtract stage SHALL remain external; the bench instantiates the existing subtract unit wired to sub_* ports.

Verification
REQ-032 rst, gate=1, attack_step=1024, tick every cycle -> levels 1024, 2048, 3072, 4095 (clamped), state DECAY.
REQ-033 From 4095, decay_step=1000, sustain=2000 -> 3095, 2095, then 2000 (clamp), state SUSTAIN.
REQ-034 SUSTAIN at 2000, gate=0, release_step=900 -> RELEASE; levels 1100, 200, then 0 via overflow, state IDLE, active=0.
REQ-035 Gate falls during ATTACK at level 2048 -> RELEASE starting from 2048; rising gate during RELEASE at 1100 -> ATTACK from 1100.
REQ-036 Gate edge and tick in same cycle -> state changes, level unchanged that cycle; tick low for 10 cycles -> level constant.
REQ-037 rst asserted in DECAY at 3095 with gate high -> level 0, IDLE next cycle; ATTACK one cycle after rst deasserts.
